// File: rtl/rca_chunk_seq.sv
`default_nettype none
// ============================================================================
// Module   : rca_chunk_seq (with helper cell full_adder)
// Brief    : Multi-cycle WIDTH-bit adder that reuses one CHUNK-bit ripple
//            chain over WIDTH/CHUNK cycles, with a start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module rca_chunk_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   result,
    output logic [WIDTH-1:0] max_val
);
    localparam int NCH  = WIDTH / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [0:0]      c_IDLE     = 1'b0;
    localparam logic [0:0]      c_RUN      = 1'b1;
    localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(NCH - 1);

    generate
        if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
            $error("rca_chunk_seq: WIDTH must be a multiple of CHUNK with 1 <= CHUNK <= WIDTH");
        end
    endgenerate

    logic [0:0]       r_state_q,  w_state_d;
    logic [IDXW-1:0]  r_idx_q,    w_idx_d;
    logic             r_carry_q,  w_carry_d;
    logic [WIDTH-1:0] r_a_q,      w_a_d;
    logic [WIDTH-1:0] r_b_q,      w_b_d;
    logic [WIDTH-1:0] r_sum_q,    w_sum_d;
    logic [WIDTH:0]   r_result_q, w_result_d;
    logic             r_done_q,   w_done_d;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_chunk_sum;
    logic [CHUNK:0]   w_rc;
    logic             w_chunk_cout;

    // Operand slice selected by the current chunk index.
    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_idx_q == IDXW'(i)) begin
                w_a_chunk = r_a_q[i*CHUNK +: CHUNK];
                w_b_chunk = r_b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    assign w_rc[0] = r_carry_q;

    generate
        for (genvar g = 0; g < CHUNK; g++) begin : g_fa
            full_adder u_fa (
                .i_a    (w_a_chunk[g]),
                .i_b    (w_b_chunk[g]),
                .i_cin  (w_rc[g]),
                .o_sum  (w_chunk_sum[g]),
                .o_cout (w_rc[g+1])
            );
        end
    endgenerate

    assign w_chunk_cout = w_rc[CHUNK];

    always_comb begin
        w_state_d  = r_state_q;
        w_idx_d    = r_idx_q;
        w_carry_d  = r_carry_q;
        w_a_d      = r_a_q;
        w_b_d      = r_b_q;
        w_sum_d    = r_sum_q;
        w_result_d = r_result_q;
        w_done_d   = 1'b0;
        case (r_state_q)
            c_IDLE: begin
                if (start) begin
                    w_state_d = c_RUN;
                    w_a_d     = a;
                    w_b_d     = b;
                    w_idx_d   = '0;
                    w_carry_d = 1'b0;
                    w_sum_d   = '0;
                end
            end
            c_RUN: begin
                for (int i = 0; i < NCH; i++) begin
                    if (r_idx_q == IDXW'(i)) begin
                        w_sum_d[i*CHUNK +: CHUNK] = w_chunk_sum;
                    end
                end
                w_carry_d = w_chunk_cout;
                w_idx_d   = r_idx_q + IDXW'(1);
                // Final slice is already merged into w_sum_d, so the result
                // load sees the complete sum in the same cycle.
                if (r_idx_q == c_LAST_IDX) begin
                    w_state_d  = c_IDLE;
                    w_idx_d    = '0;
                    w_carry_d  = 1'b0;
                    w_result_d = {w_chunk_cout, w_sum_d};
                    w_done_d   = 1'b1;
                end
            end
            default: begin
                w_state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= c_IDLE;
            r_idx_q    <= '0;
            r_carry_q  <= 1'b0;
            r_a_q      <= '0;
            r_b_q      <= '0;
            r_sum_q    <= '0;
            r_result_q <= '0;
            r_done_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_idx_q    <= w_idx_d;
            r_carry_q  <= w_carry_d;
            r_a_q      <= w_a_d;
            r_b_q      <= w_b_d;
            r_sum_q    <= w_sum_d;
            r_result_q <= w_result_d;
            r_done_q   <= w_done_d;
        end
    end

    assign busy    = (r_state_q == c_RUN);
    assign done    = r_done_q;
    assign result  = r_result_q;
    assign max_val = '1;

endmodule

`default_nettype wire

// File: tb/tb_rca_chunk_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_rca_chunk_seq
// Brief    : Scoreboard bench for rca_chunk_seq at WIDTH=16, CHUNK=4.
// Revision : 1.0 - initial release
// ============================================================================

module tb_rca_chunk_seq;
    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int NCH   = WIDTH / CHUNK;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   result;
    logic [WIDTH-1:0] max_val;

    rca_chunk_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .max_val (max_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH:0] res;
        int             cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'(result), 32'h0001_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", 32'(result), 32'(e.res));
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Called just after a negedge; returns just after the next negedge.
    task automatic start_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                            input bit accept);
        exp_t e;
        start = 1'b1;
        a     = ia;
        b     = ib;
        if (accept) begin
            e.res = {1'b0, ia} + {1'b0, ib};
            e.cyc = cyc + 1 + NCH;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("wait_timeout", sb.size(), 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", 32'(result), 0);
        check("max_val", max_val, 32'hFFFF);

        // Carry ripples through every chunk; busy exactly NCH cycles.
        start_op(16'hFFFF, 16'h0001, 1);
        for (int k = 1; k <= NCH; k++) begin
            check("busy_run", busy, 1);
            @(negedge clk);
        end
        check("busy_after", busy, 0);
        check("done_pulse", done, 1);
        @(negedge clk);
        check("done_once", done, 0);
        wait_idle();

        // Back-to-back: start on the done cycle is accepted.
        start_op(16'h1234, 16'h4321, 1);
        repeat (NCH) @(negedge clk);
        check("b2b_done", done, 1);
        start_op(16'h8000, 16'h8000, 1);
        check("b2b_busy", busy, 1);
        wait_idle();

        // Start while busy and mid-run operand changes are ignored.
        start_op(16'h00FF, 16'h0001, 1);
        start_op(16'hFFFF, 16'hFFFF, 0);
        a = 16'h5A5A;
        b = 16'hA5A5;
        wait_idle();
        repeat (6) @(negedge clk);
        check("ignored_result", 32'(result), 32'h0_0100);

        // Reset in the middle of a run aborts it.
        start_op(16'hFFFF, 16'hFFFF, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_result", 32'(result), 0);
        repeat (6) @(negedge clk);
        check("abort_no_done", done, 0);
        start_op(16'hFFFF, 16'hFFFF, 1);
        wait_idle();
        check("fresh_result", 32'(result), 32'h1_FFFE);

        // Random sweep, occasionally back-to-back on the done cycle.
        for (int i = 0; i < 1000; i++) begin
            start_op(WIDTH'($urandom), WIDTH'($urandom), 1);
            repeat (NCH) @(negedge clk);
            if ($urandom_range(0, 3) != 0) wait_idle();
        end
        wait_idle();
        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire

// File: doc/rca_chunk_seq.md
Name: rca_chunk_seq

Overview:
- Multi-cycle wide adder. Adds two WIDTH-bit operands by reusing one CHUNK-bit ripple-carry adder over WIDTH/CHUNK cycles.
- Holds the inter-chunk carry in a register between cycles.
- Controls the shared narrow adder with a start/busy/done handshake.
- Sits between operand-producing logic and consumers that need the (WIDTH+1)-bit sum, where a full-width ripple chain is too large or too slow.

Parameters:
- WIDTH, 32: operand width in bits. Must be an integer multiple of CHUNK; any other value is an elaboration error.
- CHUNK, 8: width of the internal ripple-carry adder, in bits. Range 1..WIDTH.
- NCH, WIDTH/CHUNK (localparam): number of chunk cycles per operation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new addition; accepted only in IDLE.
- a  in  WIDTH  operand A; sampled only on the accepting edge.
- b  in  WIDTH  operand B; sampled only on the accepting edge.
- busy  out  1  high while an addition is in progress (state RUN).
- done  out  1  one-cycle pulse; result has just been updated.
- result  out  WIDTH+1  {carry_out, sum} of the last completed addition.
- max_val  out  WIDTH  constant all-ones, the largest WIDTH-bit operand value.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, busy=0, done=0, result=0, chunk index=0, carry register=0, operand registers=0.
  - Reset overrides start in the same cycle.
  - Reset during RUN aborts the operation: result stays 0, no done pulse.
- FSM states: IDLE and RUN.
  - IDLE -> RUN: on an edge with start=1. Latch a and b into operand registers; idx=0; carry=0.
  - RUN: each edge computes chunk idx = A[idx*CHUNK +: CHUNK] + B[idx*CHUNK +: CHUNK] + carry.
    - The CHUNK-bit sum is written into the working sum register at the same slice.
    - carry <= chunk carry-out; idx <= idx+1.
  - RUN -> IDLE: on the edge that processes chunk NCH-1.
    - result <= {chunk carry-out, full working sum}; done <= 1.
    - Working register slices are written before the final result is formed; the final slice is merged combinationally into the result load.
- Chunk adder:
  - Built from 1-bit full_adder cells as a CHUNK-bit ripple chain.
  - Carry-in driven by the carry register. Carry-in is 0 for chunk 0 of every operation.
- Latency and handshake:
  - Start accepted at edge E0.
  - busy=1 during the cycles after E0 through edge E(NCH): exactly NCH cycles.
  - done=1 for exactly the one cycle after E(NCH).
  - result changes only at E(NCH) and holds until the next completion or reset.
- start while busy=1 is ignored; a, b and the operand registers are unaffected.
- start in the cycle done=1 is accepted (state is IDLE), giving back-to-back operations with no idle gap.
- a/b changes after the accepting edge do not affect the operation in flight.
- CHUNK=WIDTH degenerates to NCH=1: busy for 1 cycle, then done.
- Arithmetic is unsigned. result[WIDTH] is the final carry-out; no wrap inside result.
- max_val has all WIDTH bits set, independent of reset.

Test Plan (WIDTH=16, CHUNK=4, NCH=4):
- rst=1 two cycles, then idle -> busy=0, done=0, result=0x00000, max_val=0xFFFF.
- start with a=0xFFFF, b=0x0001 -> busy high 4 cycles; done pulses the 5th cycle after the start edge; result=0x10000 (carry ripples through all chunks).
- start with a=0x1234, b=0x4321 -> result=0x05555. Then start asserted on the done cycle with a=0x8000, b=0x8000 -> accepted immediately; result=0x10000 four cycles later.
- Start 0x00FF+0x0001, then assert start with a=0xFFFF, b=0xFFFF while busy and change a/b mid-run -> ignored; result=0x00100; exactly one done pulse.
- Start 0xFFFF+0xFFFF, rst=1 at the 2nd busy cycle -> busy=0 next cycle, no done, result=0. A fresh start 0xFFFF+0xFFFF completes with result=0x1FFFE.
- Random sweep of 1000 operand pairs against a reference a+b model -> all results match; each start produces exactly one done, NCH+1 cycles after the start edge.
